// File: rtl/dense_reader.sv
// Streaming read front-end: walks a RAM address range and presents bytes on a valid/ready stream.
// Optional strided addressing is enabled with `define DENSE_READER_STRIDE_EN.
module dense_reader #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [16:0] len,
`ifdef DENSE_READER_STRIDE_EN
  input  logic [15:0] stride,
`endif
  output logic [15:0] ram_address,
  output logic        ram_wren,
  input  logic [7:0]  ram_q,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_t      state_reg, state_next;
  logic [15:0] addr_reg;
  logic [16:0] len_reg;
  logic [16:0] issued_reg;
  logic [16:0] delivered_reg;
  logic        inflight_reg;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;
  logic [1:0]  count_reg;
  logic [15:0] step;
  logic        accept;
  logic        issue;
  logic        pop;
  logic [2:0]  occupancy;

`ifdef DENSE_READER_STRIDE_EN
  logic [15:0] step_reg;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      step_reg <= 16'd0;
    else if (accept)
      step_reg <= stride;
  end
  assign step = step_reg;
`else
  assign step = 16'd1;
`endif

  // Two skid entries; a read returning from the RAM lands in the slot wr_ptr_reg points at.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [7:0] entry_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          entry_reg <= 8'd0;
        else if (inflight_reg && (wr_ptr_reg == 1'(gi)))
          entry_reg <= ram_q;
      end
    end
  endgenerate

  assign ram_address = addr_reg;
  assign ram_wren    = 1'b0;
  assign out_data    = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign out_valid   = (count_reg != 2'd0);
  assign out_last    = out_valid && (delivered_reg == (len_reg - 17'd1));
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_FIN);

  // A pop this cycle frees a slot, so issue stays combinational on out_ready.
  always_comb begin
    accept    = (state_reg == S_IDLE) && start;
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
    issue     = (state_reg == S_RUN) && (issued_reg < len_reg) &&
                (occupancy < (DEPTH + {2'b00, pop}));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = (len == 17'd0) ? S_FIN : S_RUN;
      S_RUN:   if (issue && ((issued_reg + 17'd1) == len_reg)) state_next = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      addr_reg      <= 16'd0;
      len_reg       <= 17'd0;
      issued_reg    <= 17'd0;
      delivered_reg <= 17'd0;
      inflight_reg  <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (accept) begin
        addr_reg      <= base_addr;
        len_reg       <= len;
        issued_reg    <= 17'd0;
        delivered_reg <= 17'd0;
      end else begin
        if (issue) begin
          addr_reg   <= addr_reg + step;
          issued_reg <= issued_reg + 17'd1;
        end
        if (pop)
          delivered_reg <= delivered_reg + 17'd1;
      end
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      if (inflight_reg)
        wr_ptr_reg <= ~wr_ptr_reg;
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dense_reader.sv
// Self-checking bench for dense_reader: RAM model, stream monitor and address-sequence reference model.
module tb_dense_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [16:0] len = 17'd0;
  logic [15:0] stride = 16'd1;
  logic [15:0] ram_address;
  logic        ram_wren;
  logic [7:0]  ram_q = 8'd0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;

  dense_reader #(.BUF_DEPTH(2)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .len(len),
`ifdef DENSE_READER_STRIDE_EN
    .stride(stride),
`endif
    .ram_address(ram_address),
    .ram_wren(ram_wren),
    .ram_q(ram_q),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:65535];
  always @(posedge clock) ram_q <= mem[ram_address];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stream monitor, sampling on the falling edge.
  bit         mon_en = 1'b0;
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         xcyc_q[$];
  logic [7:0] exp_q[$];
  int         first_valid_cyc;
  int         done_cnt;
  int         done_cyc;
  int         stab_err;
  bit         prev_stall;
  logic [7:0] prev_data;

  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        xcyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    xcyc_q.delete();
    first_valid_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    stab_err = 0;
    prev_stall = 1'b0;
  endtask

  // Reference: byte i comes from address (base + i*step) mod 2^16.
  task automatic build_exp(input logic [15:0] b, input int n, input logic [15:0] s);
    int step;
    exp_q.delete();
`ifdef DENSE_READER_STRIDE_EN
    step = int'(s);
`else
    step = (s == s) ? 1 : 1;
`endif
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i * step) % 65536]);
  endtask

  function automatic logic pick_ready(input int pct);
    if (pct >= 100) return 1'b1;
    return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
  endfunction

  // Issues one command and clocks until busy falls; restart_k >= 0 pulses a second start mid-command.
  task automatic run_cmd(input logic [15:0] b, input int n, input logic [15:0] s, input int pct,
                         input int restart_k, output int start_cyc, output bit timeout);
    int k;
    clear_mon();
    mon_en = 1'b1;
    @(posedge clock); #1;
    base_addr = b; len = 17'(n); stride = s; start = 1'b1;
    out_ready = pick_ready(pct);
    start_cyc = cyc + 1;
    @(posedge clock); #1;
    start = 1'b0; base_addr = ~b; len = 17'd9;
    timeout = 1'b1;
    for (k = 0; k < 3000; k++) begin
      if (!busy && k > 0) begin
        timeout = 1'b0;
        break;
      end
      start = (k == restart_k);
      if (k == restart_k) begin
        base_addr = 16'h4000; len = 17'd5;
      end
      out_ready = pick_ready(pct);
      @(posedge clock); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (ram_address !== 16'd0) begin bad++; $display("FAIL reset ram_address got %h exp 0000", ram_address); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset out_last got %b exp 0", out_last); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset out_data got %h exp 00", out_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset busy/done got %b%b exp 00", busy, done); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL reset ram_wren got %b exp 0", ram_wren); end
    reset_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    int sc; bit to;
    run_cmd(16'h0010, 4, 16'd1, 100, -1, sc, to);
    build_exp(16'h0010, 4, 16'd1);
    total++; if (to || got_q.size() != 4) begin bad++; $display("FAIL basic count got %0d exp 4 timeout=%0d", got_q.size(), to); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3)) begin
        bad++; $display("FAIL basic byte[%0d] got %h/last%0d exp %h/last%0d", i, got_q[i], last_q[i], exp_q[i], (i == 3));
      end
      total++; if (xcyc_q[i] != sc + 2 + i) begin bad++; $display("FAIL basic xfer_cycle[%0d] got %0d exp %0d", i, xcyc_q[i] - sc, 2 + i); end
    end
    total++; if (first_valid_cyc - sc != 2) begin bad++; $display("FAIL basic latency got %0d exp 2", first_valid_cyc - sc); end
    total++; if (done_cnt != 1 || done_cyc != sc + 6) begin bad++; $display("FAIL basic done cnt=%0d at %0d exp cnt=1 at 6", done_cnt, done_cyc - sc); end
    $display("basic: base=0010 len=4 bytes=%0d done_cnt=%0d", got_q.size(), done_cnt);
  endtask

  task automatic test_wrap();
    int sc; bit to;
    logic [7:0] want [4];
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_cmd(16'hFFFE, 4, 16'd1, 100, -1, sc, to);
    total++; if (to || got_q.size() != 4) begin bad++; $display("FAIL wrap count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== want[i]) begin bad++; $display("FAIL wrap byte[%0d] got %h exp %h", i, got_q[i], want[i]); end
    end
    $display("wrap: base=FFFE len=4 bytes=%0d", got_q.size());
  endtask

  task automatic test_backpressure();
    int sc; bit to;
    run_cmd(16'h0123, 16, 16'd1, 45, -1, sc, to);
    build_exp(16'h0123, 16, 16'd1);
    total++; if (to || got_q.size() != 16) begin bad++; $display("FAIL stall count got %0d exp 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 15)) begin
        bad++; $display("FAIL stall byte[%0d] got %h/last%0d exp %h/last%0d", i, got_q[i], last_q[i], exp_q[i], (i == 15));
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL stall stability errors got %0d exp 0", stab_err); end
    total++; if (done_cnt != 1 || (xcyc_q.size() > 0 && done_cyc != xcyc_q[xcyc_q.size() - 1] + 1)) begin
      bad++; $display("FAIL stall done cnt=%0d cyc=%0d", done_cnt, done_cyc);
    end
    $display("backpressure: len=16 bytes=%0d stab_err=%0d", got_q.size(), stab_err);
  endtask

  task automatic test_len_zero();
    int sc; bit to;
    run_cmd(16'h0200, 0, 16'd1, 100, 0, sc, to);
    total++; if (to || done_cnt != 1 || done_cyc != sc) begin
      bad++; $display("FAIL len0 done cnt=%0d at %0d exp cnt=1 at 0", done_cnt, done_cyc - sc);
    end
    total++; if (first_valid_cyc != -1 || got_q.size() != 0) begin
      bad++; $display("FAIL len0 out_valid seen at %0d bytes=%0d exp none", first_valid_cyc, got_q.size());
    end
    $display("len_zero: done_cnt=%0d bytes=%0d", done_cnt, got_q.size());
  endtask

  task automatic test_start_ignored();
    int sc; bit to;
    run_cmd(16'h0050, 4, 16'd1, 100, 1, sc, to);
    build_exp(16'h0050, 4, 16'd1);
    total++; if (to || got_q.size() != 4 || done_cnt != 1) begin
      bad++; $display("FAIL restart bytes=%0d done_cnt=%0d exp 4/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    $display("start_ignored: bytes=%0d done_cnt=%0d", got_q.size(), done_cnt);
  endtask

  task automatic test_reset_midstream();
    int sc; bit to; int k;
    clear_mon();
    mon_en = 1'b1;
    @(posedge clock); #1;
    base_addr = 16'h0020; len = 17'd8; start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (k = 0; k < 50 && got_q.size() < 3; k++) begin
      @(posedge clock); #1;
    end
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL midreset pre-bytes got %0d exp 3", got_q.size()); end
    mon_en = 1'b0;
    reset_n = 1'b0;
    #2;
    total++; if ({ram_address, out_valid, out_last, out_data, busy, done} !== 28'd0) begin
      bad++; $display("FAIL midreset outputs addr=%h v=%b l=%b d=%h busy=%b done=%b exp all 0",
                      ram_address, out_valid, out_last, out_data, busy, done);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    run_cmd(16'h0030, 2, 16'd1, 100, -1, sc, to);
    build_exp(16'h0030, 2, 16'd1);
    total++; if (to || got_q.size() != 2 || done_cnt != 1) begin
      bad++; $display("FAIL midreset after bytes=%0d done_cnt=%0d exp 2/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 1)) begin
        bad++; $display("FAIL midreset byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    $display("reset_midstream: bytes after reset=%0d", got_q.size());
  endtask

  task automatic test_random();
    int sc; bit to; int n; logic [15:0] b; logic [15:0] s; int pct;
    for (int r = 0; r < 4; r++) begin
      b = 16'($urandom);
      n = $urandom_range(1, 40);
      s = 16'($urandom_range(0, 700));
      pct = $urandom_range(20, 100);
      run_cmd(b, n, s, pct, -1, sc, to);
      build_exp(b, n, s);
      total++; if (to || got_q.size() != n || done_cnt != 1) begin
        bad++; $display("FAIL random[%0d] bytes=%0d done_cnt=%0d exp %0d/1", r, got_q.size(), done_cnt, n);
      end
      for (int i = 0; i < n && i < got_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == n - 1)) begin
          bad++; $display("FAIL random[%0d] byte[%0d] got %h exp %h", r, i, got_q[i], exp_q[i]);
        end
      end
      total++; if (stab_err != 0) begin bad++; $display("FAIL random[%0d] stability errors %0d exp 0", r, stab_err); end
      $display("random[%0d]: base=%h len=%0d stride=%h ready%%=%0d bytes=%0d", r, b, n, s, pct, got_q.size());
    end
  endtask

`ifdef DENSE_READER_STRIDE_EN
  task automatic test_stride();
    int sc; bit to;
    logic [7:0] want [3];
    mem[16'h0100] = 8'hA5;
    mem[16'h0200] = 8'h5A;
    want = '{8'h00, 8'hA5, 8'h5A};
    run_cmd(16'h0000, 3, 16'h0100, 100, -1, sc, to);
    total++; if (to || got_q.size() != 3) begin bad++; $display("FAIL stride count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== want[i]) begin bad++; $display("FAIL stride byte[%0d] got %h exp %h", i, got_q[i], want[i]); end
    end
    $display("stride: stride=0100 len=3 bytes=%0d", got_q.size());
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_ignored();
    test_reset_midstream();
`ifdef DENSE_READER_STRIDE_EN
    test_stride();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
